// File: rtl/wb_mem_arbiter.sv
// Two-master, one-slave Wishbone-classic arbiter: instruction fetch and data
// ports share one memory port through a registered FSM with an ack timeout.
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    instr_cyc_i,
  input  logic                    instr_stb_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_data_o,
  output logic                    instr_ack_o,
  output logic                    instr_err_o,

  input  logic                    data_cyc_i,
  input  logic                    data_stb_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_sel_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_data_i,
  output logic [DATA_WIDTH-1:0]   data_data_o,
  output logic                    data_ack_o,
  output logic                    data_err_o,

  output logic                    mem_cyc_o,
  output logic                    mem_stb_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_sel_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  input  logic                    mem_ack_i,

  output logic [1:0]              grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_INSTR = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] tmo_cnt;
  logic                 last_grant_data;
  logic                 owner_dropped;

  logic instr_req;
  logic data_req;
  logic pick_data;
  logic timeout_hit;
  logic owner_cyc;
  logic suppress_resp;

  // Round-robin favours the port that did not win last; mode 1 lets data always win.
  always_comb begin
    instr_req     = instr_cyc_i & instr_stb_i;
    data_req      = data_cyc_i & data_stb_i;
    pick_data     = data_req & (~instr_req | (PRIORITY_MODE != 0) | ~last_grant_data);
    timeout_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
    owner_cyc     = (state == S_BUSY_D) ? data_cyc_i : instr_cyc_i;
    suppress_resp = owner_dropped | ~owner_cyc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      tmo_cnt         <= '0;
      last_grant_data <= 1'b1;
      owner_dropped   <= 1'b0;
      grant_o         <= GRANT_NONE;
      mem_cyc_o       <= 1'b0;
      mem_stb_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_sel_o       <= '0;
      mem_addr_o      <= '0;
      mem_data_o      <= '0;
      instr_data_o    <= '0;
      instr_ack_o     <= 1'b0;
      instr_err_o     <= 1'b0;
      data_data_o     <= '0;
      data_ack_o      <= 1'b0;
      data_err_o      <= 1'b0;
    end else begin
      instr_ack_o <= 1'b0;
      instr_err_o <= 1'b0;
      data_ack_o  <= 1'b0;
      data_err_o  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (instr_req | data_req) begin
            mem_cyc_o     <= 1'b1;
            mem_stb_o     <= 1'b1;
            tmo_cnt       <= '0;
            owner_dropped <= 1'b0;
            if (pick_data) begin
              mem_addr_o      <= data_addr_i;
              mem_we_o        <= data_we_i;
              mem_sel_o       <= data_sel_i;
              mem_data_o      <= data_data_i;
              grant_o         <= GRANT_DATA;
              last_grant_data <= 1'b1;
              state           <= S_BUSY_D;
            end else begin
              mem_addr_o      <= instr_addr_i;
              mem_we_o        <= 1'b0;
              mem_sel_o       <= {SEL_WIDTH{1'b1}};
              mem_data_o      <= '0;
              grant_o         <= GRANT_INSTR;
              last_grant_data <= 1'b0;
              state           <= S_BUSY_I;
            end
          end
        end

        // An abandoned transaction still runs to completion on the slave side,
        // only the response pulse to the master is withheld.
        S_BUSY_I, S_BUSY_D: begin
          if (!owner_cyc) begin
            owner_dropped <= 1'b1;
          end
          if (mem_ack_i) begin
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            state     <= S_RESP;
            if (state == S_BUSY_D) begin
              data_data_o <= mem_data_i;
              data_ack_o  <= ~suppress_resp;
            end else begin
              instr_data_o <= mem_data_i;
              instr_ack_o  <= ~suppress_resp;
            end
          end else if (timeout_hit) begin
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            state     <= S_RESP;
            if (state == S_BUSY_D) begin
              data_data_o <= '0;
              data_err_o  <= ~suppress_resp;
            end else begin
              instr_data_o <= '0;
              instr_err_o  <= ~suppress_resp;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          grant_o <= GRANT_NONE;
          state   <= S_IDLE;
        end

        default: begin
          grant_o <= GRANT_NONE;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration and memory contents.
module tb_wb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_cyc, instr_stb;
  logic [31:0] instr_addr;
  logic        data_cyc, data_stb, data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr, data_wdata;

  logic [31:0] idata0, ddata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        iack0, ierr0, dack0, derr0, mem_cyc0, mem_stb0, mem_we0, mem_ack0;
  logic [3:0]  mem_sel0;
  logic [1:0]  grant0;

  logic [31:0] idata1, ddata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        iack1, ierr1, dack1, derr1, mem_cyc1, mem_stb1, mem_we1, mem_ack1;
  logic [3:0]  mem_sel1;
  logic [1:0]  grant1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .rst(rst),
    .instr_cyc_i(instr_cyc), .instr_stb_i(instr_stb), .instr_addr_i(instr_addr),
    .instr_data_o(idata0), .instr_ack_o(iack0), .instr_err_o(ierr0),
    .data_cyc_i(data_cyc), .data_stb_i(data_stb), .data_we_i(data_we),
    .data_sel_i(data_sel), .data_addr_i(data_addr), .data_data_i(data_wdata),
    .data_data_o(ddata0), .data_ack_o(dack0), .data_err_o(derr0),
    .mem_cyc_o(mem_cyc0), .mem_stb_o(mem_stb0), .mem_we_o(mem_we0),
    .mem_sel_o(mem_sel0), .mem_addr_o(mem_addr0), .mem_data_o(mem_wdata0),
    .mem_data_i(mem_rdata0), .mem_ack_i(mem_ack0), .grant_o(grant0)
  );

  wb_mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .rst(rst),
    .instr_cyc_i(instr_cyc), .instr_stb_i(instr_stb), .instr_addr_i(instr_addr),
    .instr_data_o(idata1), .instr_ack_o(iack1), .instr_err_o(ierr1),
    .data_cyc_i(data_cyc), .data_stb_i(data_stb), .data_we_i(data_we),
    .data_sel_i(data_sel), .data_addr_i(data_addr), .data_data_i(data_wdata),
    .data_data_o(ddata1), .data_ack_o(dack1), .data_err_o(derr1),
    .mem_cyc_o(mem_cyc1), .mem_stb_o(mem_stb1), .mem_we_o(mem_we1),
    .mem_sel_o(mem_sel1), .mem_addr_o(mem_addr1), .mem_data_o(mem_wdata1),
    .mem_data_i(mem_rdata1), .mem_ack_i(mem_ack1), .grant_o(grant1)
  );

  // Second DUT sits on a zero-wait slave that always returns zero.
  assign mem_ack1   = mem_cyc1 & mem_stb1;
  assign mem_rdata1 = 32'h0;

  // Slave for dut0: acks after slave_wait busy cycles, never when slave_wait < 0.
  int          slave_wait = 0;
  int          busy_cnt   = 0;
  logic [31:0] slave_mem [16];

  assign mem_rdata0 = slave_mem[mem_addr0[5:2]];

  always @(negedge clk) begin
    if (mem_cyc0 && mem_stb0) begin
      mem_ack0 = (slave_wait >= 0) && (busy_cnt == slave_wait);
      busy_cnt++;
    end else begin
      mem_ack0 = 1'b0;
      busy_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slave_mem[i] <= (32'(i) << 24) | 32'h13;
    end else if (mem_cyc0 && mem_stb0 && mem_ack0 && mem_we0) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel0[b]) slave_mem[mem_addr0[5:2]][8*b +: 8] <= mem_wdata0[8*b +: 8];
    end
  end

  // Transaction-level reference state.
  logic [31:0] model_mem [16];
  bit          model_last_d;
  logic [31:0] model_idata, model_ddata;
  bit          check_dut1 = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = (32'(i) << 24) | 32'h13;
    model_last_d = 1;
    model_idata  = 32'h0;
    model_ddata  = 32'h0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyIdle();
    instr_cyc = 0; instr_stb = 0; instr_addr = 32'h0;
    data_cyc = 0; data_stb = 0; data_we = 0; data_sel = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " grant"}, 64'(grant0), 64'h0);
    check({tag, " mem_ctl"}, 64'({mem_cyc0, mem_stb0, mem_we0, mem_sel0}), 64'h0);
    check({tag, " mem_addr"}, 64'(mem_addr0), 64'h0);
    check({tag, " mem_wdata"}, 64'(mem_wdata0), 64'h0);
    check({tag, " rdata"}, {idata0, ddata0}, 64'h0);
    check({tag, " pulses"}, 64'({iack0, ierr0, dack0, derr0}), 64'h0);
  endtask

  // One complete transaction starting from IDLE, #1 after a clock edge.
  // wt < 0 means the slave never acks and a timeout is expected.
  task automatic applyStimulus(input bit ri, input bit rd, input bit we,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] sel,
                               input int wt, input bit keep_req);
    bit          win_d;
    logic [31:0] exp_addr, exp_rd;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_grant;
    int          idx;

    instr_cyc = ri; instr_stb = ri; instr_addr = ia;
    data_cyc = rd; data_stb = rd; data_we = we; data_sel = sel;
    data_addr = da; data_wdata = wd;
    slave_wait = wt;

    win_d        = rd && (!ri || !model_last_d);
    model_last_d = win_d;
    exp_addr     = win_d ? da : ia;
    exp_sel      = win_d ? sel : 4'hF;
    exp_grant    = win_d ? 2'b10 : 2'b01;
    idx          = int'(exp_addr[5:2]);

    @(posedge clk); #1;
    check("grant", 64'(grant0), 64'(exp_grant));
    check("mem_cyc_stb", 64'({mem_cyc0, mem_stb0}), 64'h3);
    check("mem_addr", 64'(mem_addr0), 64'(exp_addr));
    check("mem_we_sel", 64'({mem_we0, mem_sel0}), 64'({win_d & we, exp_sel}));
    if (win_d) check("mem_wdata", 64'(mem_wdata0), 64'(wd));
    if (check_dut1) check("prio_grant", 64'(grant1), 64'h2);

    for (int k = 0; k < ((wt < 0) ? TMO : wt); k++) begin
      @(posedge clk); #1;
      check("busy_hold", 64'({mem_cyc0, mem_stb0, mem_addr0}), {30'h0, 2'b11, exp_addr});
      check("busy_quiet", 64'({iack0, ierr0, dack0, derr0}), 64'h0);
    end

    exp_rd = (wt < 0) ? 32'h0 : model_mem[idx];
    @(posedge clk); #1;
    check("done_mem_cyc", 64'({mem_cyc0, mem_stb0}), 64'h0);
    check("done_grant", 64'(grant0), 64'(exp_grant));
    if (win_d) begin
      check("d_ack_err", 64'({dack0, derr0}), (wt < 0) ? 64'h1 : 64'h2);
      check("i_ack_err", 64'({iack0, ierr0}), 64'h0);
      check("d_data", 64'(ddata0), 64'(exp_rd));
      check("i_data_kept", 64'(idata0), 64'(model_idata));
      model_ddata = exp_rd;
      if (wt >= 0 && we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end else begin
      check("i_ack_err", 64'({iack0, ierr0}), (wt < 0) ? 64'h1 : 64'h2);
      check("d_ack_err", 64'({dack0, derr0}), 64'h0);
      check("i_data", 64'(idata0), 64'(exp_rd));
      check("d_data_kept", 64'(ddata0), 64'(model_ddata));
      model_idata = exp_rd;
    end
    if (!keep_req) applyIdle();

    @(posedge clk); #1;
    check("resp_end_grant", 64'(grant0), 64'h0);
    check("resp_end_pulses", 64'({iack0, ierr0, dack0, derr0}), 64'h0);
  endtask

  task automatic checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    applyIdle();
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 0;

    // Continuous contention: mode 0 alternates I,D,... ; mode 1 always data.
    check_dut1 = 1;
    for (int k = 0; k < 6; k++) begin
      check("rr_order_pre", 64'(model_last_d), (k % 2 == 0) ? 64'h1 : 64'h0);
      applyStimulus(1, 1, 0, 32'h0000_0044, 32'h0000_0048, 32'h0, 4'hF, 0, 1);
    end
    check_dut1 = 0;
    applyIdle();
    repeat (3) @(posedge clk);
    #1;

    // Instruction fetch from 0x40 on a zero-wait slave returns 0x13.
    applyStimulus(1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 4'h0, 0, 0);
    check("fetch_0x40", 64'(idata0), 64'h13);

    // Partial data write.
    applyStimulus(0, 1, 1, 32'h0, 32'h1000_0004, 32'hCAFE_BABE, 4'b0011, 1, 0);

    // Slave never acks: timeout error, then normal service resumes.
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0008, 32'h0, 4'hF, -1, 0);
    applyStimulus(0, 1, 0, 32'h0, 32'h0000_0004, 32'h0, 4'hF, 0, 0);
    check("write_readback", 64'(ddata0), 64'h0100_BABE);

    // Reset in the second busy cycle aborts without any response.
    instr_cyc = 1; instr_stb = 1; instr_addr = 32'h0000_000C; slave_wait = 1;
    @(posedge clk); #1;
    check("rst_grant", 64'(grant0), 64'h1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    checkResetOutputs("midrst");
    applyIdle();
    @(posedge clk); #1;
    check("midrst_no_ack", 64'({iack0, ierr0}), 64'h0);
    rst = 0;
    model_reset();
    applyStimulus(1, 0, 0, 32'h0000_000C, 32'h0, 32'h0, 4'h0, 0, 0);

    // Owner abandons the cycle mid-busy; slave acks three cycles in.
    data_cyc = 1; data_stb = 1; data_we = 0; data_sel = 4'hF;
    data_addr = 32'h0000_0018; slave_wait = 3;
    model_last_d = 1;
    @(posedge clk); #1;
    check("drop_grant", 64'(grant0), 64'h2);
    @(posedge clk); #1;
    applyIdle();
    repeat (2) begin
      @(posedge clk); #1;
      check("drop_busy", 64'(mem_cyc0), 64'h1);
    end
    @(posedge clk); #1;
    check("drop_no_ack", 64'({iack0, ierr0, dack0, derr0, mem_cyc0}), 64'h0);
    model_ddata = model_mem[6];
    @(posedge clk); #1;
    check("drop_idle", 64'(grant0), 64'h0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 24; k++) begin
      int          ports;
      int          wt;
      logic [31:0] ra, rb, rw;
      ports = int'($urandom_range(1, 3));
      wt    = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 3));
      ra    = $urandom & 32'hFFFF_FFFC;
      rb    = $urandom & 32'hFFFF_FFFC;
      rw    = $urandom;
      applyStimulus(ports[0], ports[1], 1'($urandom_range(0, 1)), ra, rb, rw,
                    4'($urandom_range(1, 15)), wt, 0);
    end

    checkOutput();
    $finish;
  end

endmodule
